// File: rtl/amiga_clock_phase_gen_if.sv
// amiga_clock_phase_gen_if: sync inputs and phase/lock outputs of the Agnus clock phase generator
interface amiga_clock_phase_gen_if;
   logic       sync_en;
   logic       sync_in;
   logic [2:0] phase;
   logic       c7m;
   logic       cck;
   logic       cckq;
   logic       cck_rise_stb;
   logic       cck_fall_stb;
   logic       c7m_rise_stb;
   logic       locked;
   logic       slip_stb;
   logic [7:0] slip_count;
   modport master (
      output sync_en, sync_in,
      input  phase, c7m, cck, cckq, cck_rise_stb, cck_fall_stb, c7m_rise_stb, locked, slip_stb, slip_count
   );
   modport slave (
      input  sync_en, sync_in,
      output phase, c7m, cck, cckq, cck_rise_stb, cck_fall_stb, c7m_rise_stb, locked, slip_stb, slip_count
   );
endinterface

// File: rtl/amiga_clock_phase_gen.sv
// amiga_clock_phase_gen: 8-phase C7M/CCK/CCKQ generator on the 28 MHz clock with optional CCK pin lock
module amiga_clock_phase_gen #(
   parameter int SYNC_PHASE   = 3,
   parameter int LOCK_COUNT   = 4,
   parameter int SYNC_TIMEOUT = 64
)(
   input logic hclkin,
   input logic reset,
   amiga_clock_phase_gen_if.slave bus
);
   localparam logic [2:0] RESYNC_P = 3'(SYNC_PHASE + 1);
   logic [2:0] p, p_nxt;
   logic       s1, s2, s3, sync_evt;
   logic       qevt, mismatch, tmo, kill;
   logic [3:0] lock_cnt;
   logic [7:0] timer;
   assign bus.phase = p;
   // next phase and lock-kill conditions; a match also lands on SYNC_PHASE+1, so any event reloads
   always_comb begin
      qevt     = sync_evt & bus.sync_en;
      mismatch = qevt & (p != 3'(SYNC_PHASE));
      tmo      = bus.sync_en & ~qevt & (timer >= 8'(SYNC_TIMEOUT - 1));
      kill     = ~bus.sync_en | mismatch | tmo;
      p_nxt    = qevt ? RESYNC_P : p + 3'd1;
   end
   // phase counter with levels and strobes decoded from next phase so they line up with p
   always_ff @(posedge hclkin or posedge reset) begin
      if (reset) begin
         p                <= 3'd0;
         bus.c7m          <= 1'b1;
         bus.cck          <= 1'b1;
         bus.cckq         <= 1'b0;
         bus.cck_rise_stb <= 1'b1;
         bus.cck_fall_stb <= 1'b0;
         bus.c7m_rise_stb <= 1'b1;
      end else begin
         p                <= p_nxt;
         bus.c7m          <= ~p_nxt[1];
         bus.cck          <= ~p_nxt[2];
         bus.cckq         <= p_nxt[2] ^ p_nxt[1];
         bus.cck_rise_stb <= p_nxt == 3'd0;
         bus.cck_fall_stb <= p_nxt == 3'd4;
         bus.c7m_rise_stb <= p_nxt[1:0] == 2'd0;
      end
   end
   // two-flop synchronizer plus registered rising-edge detect on the CCK reference pin
   always_ff @(posedge hclkin or posedge reset) begin
      if (reset) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         sync_evt <= 1'b0;
      end else begin
         s1       <= bus.sync_in;
         s2       <= s1;
         s3       <= s2;
         sync_evt <= s2 & ~s3;
      end
   end
   // lock qualification, sync timeout and slip accounting
   always_ff @(posedge hclkin or posedge reset) begin
      if (reset) begin
         lock_cnt       <= 4'd0;
         timer          <= 8'd0;
         bus.locked     <= 1'b0;
         bus.slip_stb   <= 1'b0;
         bus.slip_count <= 8'd0;
      end else begin
         lock_cnt       <= kill ? 4'd0 : (qevt && lock_cnt != 4'(LOCK_COUNT)) ? lock_cnt + 4'd1 : lock_cnt;
         timer          <= (~bus.sync_en | qevt) ? 8'd0 : (timer == 8'hff) ? timer : timer + 8'd1;
         bus.locked     <= ~kill & (lock_cnt == 4'(LOCK_COUNT));
         bus.slip_stb   <= mismatch;
         bus.slip_count <= (mismatch && bus.slip_count != 8'hff) ? bus.slip_count + 8'd1 : bus.slip_count;
      end
   end
endmodule

// File: doc/amiga_clock_phase_gen.md
Name: amiga_clock_phase_gen

Overview:
- Runs in the 28 MHz master-clock domain, the same clock that feeds the /4 C7M divider.
- Produces phase-exact C7M, CCK and CCKQ levels, plus one-cycle enable strobes, so the rest of Agnus logic stays single-clock.
- Optionally aligns its 8-cycle phase counter to an external CCK reference pin and reports lock and slip status.

Parameters:
- SYNC_PHASE, 3, phase counter value expected in the cycle a synchronized sync edge is seen; covers the 2FF and edge-detect latency.
- LOCK_COUNT, 4, number of consecutive matching sync edges needed to assert locked (1..15).
- SYNC_TIMEOUT, 64, cycles without a sync edge after which locked drops (16..255).

Ports:
- hclkin  in  1  28 MHz master clock.
- reset  in  1  asynchronous, active-high reset.
- sync_en  in  1  enables alignment to sync_in; when 0, sync edges are ignored.
- sync_in  in  1  asynchronous external CCK reference.
- phase  out  3  current phase counter p.
- c7m  out  1  C7M level.
- cck  out  1  CCK level.
- cckq  out  1  CCKQ level (CCK delayed 90°).
- cck_rise_stb  out  1  high for one cycle when p==0.
- cck_fall_stb  out  1  high for one cycle when p==4.
- c7m_rise_stb  out  1  high for one cycle when p==0 or p==4.
- locked  out  1  phase lock achieved.
- slip_stb  out  1  one-cycle pulse on each phase correction.
- slip_count  out  8  saturating count of corrections.

Behaviour:
- Clock and reset: all state is on the rising edge of hclkin. Reset is asynchronous, active-high.
- Reset values: p=0, c7m=1, cck=1, cckq=0, cck_rise_stb=1, cck_fall_stb=0, c7m_rise_stb=1, locked=0, slip_stb=0, slip_count=0. Synchronizer flops, lock counter and timeout timer also clear.
- Phase counter: p increments by 1 mod 8 every cycle, wrapping 7→0.
- Level and strobe outputs: registered, decoded from next-p, so each equals decode(p) in the same cycle.
  - c7m = ~p[1], high for p in {0,1,4,5}.
  - cck = ~p[2], high for p in 0..3.
  - cckq = p[2]^p[1], high for p in 2..5.
  - Strobes decode as listed under Ports.
- Sync path:
  - sync_in passes through a 2FF synchronizer, then a registered rising-edge detect, giving sync_evt.
  - sync_evt fires 3 cycles after the pin edge (±1 for metastability).
  - sync_evt is qualified by sync_en.
- On a qualified sync_evt with p==SYNC_PHASE (match):
  - Lock counter increments, saturating at LOCK_COUNT.
  - locked sets in the cycle after the counter reaches LOCK_COUNT.
  - Timeout timer clears.
- On a qualified sync_evt with p!=SYNC_PHASE (mismatch):
  - Next p = (SYNC_PHASE+1) mod 8, so the correction takes effect in the following cycle and outputs are re-decoded from the corrected p.
  - Lock counter and locked clear; slip_stb pulses for one cycle; slip_count increments and saturates at 255.
  - Timeout timer clears.
  - Output levels may show one shortened or stretched phase. This is accepted.
- Timeout timer:
  - Increments every cycle while sync_en=1 and no sync_evt occurs, saturating.
  - When it reaches SYNC_TIMEOUT: locked clears and the lock counter clears. p keeps free-running; no slip is recorded.
  - Timeout and sync_evt in the same cycle: sync_evt wins and the timer clears.
- sync_en=0: sync_evt is ignored; locked and the lock counter clear in the next cycle; the timer is held at 0; slip_count holds its value.
- sync_en rising: the synchronizer is not flushed, so an edge already in flight may be acted on.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously). Counting resumes from p=0 on the first clock after deassertion.
- No combinational path from any input to any output.

Test Plan:
- Reset, sync_en=0, run 16 cycles -> phase 0,1,…,7,0; c7m=1,1,0,0,1,1,0,0; cck=1 for p 0-3; cckq=1 for p 2-5; cck_rise_stb at p=0, cck_fall_stb at p=4, c7m_rise_stb at p=0/4 only.
- sync_en=1, sync_in square wave (period 8) aligned so sync_evt lands at p=3 -> no slip_stb; locked rises after the 4th matching edge; slip_count stays 0.
- While locked, shift the sync_in phase by +2 cycles -> exactly one slip_stb, slip_count=1, locked drops; p jumps to 4 the cycle after sync_evt; relock after 4 further matching edges.
- While locked, hold sync_in low for 70 cycles -> locked drops exactly SYNC_TIMEOUT=64 cycles after the last sync_evt; phase keeps counting; slip_count unchanged.
- Force 300 mismatching edges -> slip_count saturates at 255, with no wrap to 0.
- Assert reset at p=5 while locked with slip_count=3 -> all outputs immediately at reset values (phase=0, locked=0, slip_count=0); counting restarts at p=0 after release.
